// File: rtl/gray_conv_pkg.sv
// Shared constants and types for the Gray-to-binary round-robin converter.
package gray_conv_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 4;
  localparam int unsigned DEFAULT_NUM_REQ = 4;

  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEFAULT_ID_W = id_width(DEFAULT_NUM_REQ);

  typedef struct packed {
    logic [DEFAULT_ID_W-1:0]  id;
    logic [DEFAULT_WIDTH-1:0] bin;
  } result_t;

endpackage

// File: rtl/gray2bin_core.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      acc                = acc ^ gray[WIDTH-1-k];
      bin[WIDTH-1-k]     = acc;
    end
  end

endmodule

// File: rtl/gray_conv_rr_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among NUM_REQ requesters,
// with a single registered valid/ready result port.
module gray_conv_rr_arbiter
  import gray_conv_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_gray,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_bin,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready
);

  // Same {id, bin} layout as the package record, sized by this instance's parameters.
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] bin;
  } res_t;

  logic             out_valid_q, out_valid_d;
  res_t             result_q, result_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;

  logic             can_accept;
  logic             found;
  logic             accept;
  int unsigned      grant_idx;
  int unsigned      cand;
  logic [WIDTH-1:0] granted_gray;
  logic [WIDTH-1:0] granted_bin;

  // Rotating-priority search: first valid requester at or after ptr, wrapping.
  always_comb begin
    can_accept = !out_valid_q || out_ready;
    found      = 1'b0;
    grant_idx  = 0;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    accept = can_accept && found && !rst;
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign granted_gray = req_gray[grant_idx*WIDTH +: WIDTH];

  gray2bin_core #(.WIDTH(WIDTH)) u_conv (
    .gray (granted_gray),
    .bin  (granted_bin)
  );

  // Accept and drain may coincide; a drain without accept keeps the last result visible.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      result_d.id  = ID_W'(grant_idx);
      result_d.bin = granted_bin;
      ptr_d        = (grant_idx == NUM_REQ - 1) ? '0 : ID_W'(grant_idx + 1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = result_q.bin;
  assign out_id    = result_q.id;

endmodule

// File: tb/tb_gray_conv_rr_arbiter.sv
// Directed bench for gray_conv_rr_arbiter with a cycle-level behavioural model checked every cycle.
module tb_gray_conv_rr_arbiter;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_gray;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_bin;
  logic [1:0]     out_id;
  logic           out_ready;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gray_conv_rr_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_gray  (req_gray),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference conversion: binary = g ^ g>>1 ^ g>>2 ^ ...
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int s = 1; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Behavioural model state
  bit           started = 0;
  bit           m_valid = 0, n_valid;
  logic [W-1:0] m_bin = '0, n_bin;
  int           m_id = 0, n_id;
  int           m_ptr = 0, n_ptr;

  always begin : model
    int g;
    bit can;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    can = !m_valid || out_ready;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = '0;
    if (!rst && can && g >= 0) exp_rdy[g] = 1'b1;
    if (started) begin
      chk("model_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("model_out_valid", 32'(out_valid), 32'(m_valid));
      chk("model_out_bin",   32'(out_bin),   32'(m_bin));
      chk("model_out_id",    32'(out_id),    32'(m_id));
    end
    n_valid = m_valid; n_bin = m_bin; n_id = m_id; n_ptr = m_ptr;
    if (rst) begin
      n_valid = 0; n_bin = '0; n_id = 0; n_ptr = 0;
    end else if (can && g >= 0) begin
      n_valid = 1;
      n_bin   = g2b(req_gray[g*W +: W]);
      n_id    = g;
      n_ptr   = (g + 1) % N;
    end else if (out_ready) begin
      n_valid = 0;
    end
    @(posedge clk);
    m_valid = n_valid; m_bin = n_bin; m_id = n_id; m_ptr = n_ptr;
    started = 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_gray(input int r, input logic [W-1:0] g);
    req_gray[r*W +: W] = g;
  endtask

  logic [W-1:0] lit_g [4] = '{4'b0000, 4'b0110, 4'b1000, 4'b0001};
  logic [W-1:0] lit_b [4] = '{4'b0000, 4'b0100, 4'b1111, 4'b0001};
  logic [N-1:0] rr_hot [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [W-1:0] hold_bin;

  initial begin
    rst = 1'b1; req_valid = '0; req_gray = '0; out_ready = 1'b1;
    cyc(); cyc();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_bin",   32'(out_bin),   32'd0);
    chk("reset_out_id",    32'(out_id),    32'd0);
    rst = 1'b0;

    // Single request
    req_valid = 4'b0001; set_gray(0, 4'b1011);
    #1 chk("single_ready", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_bin",   32'(out_bin),   32'b1101);
    chk("single_id",    32'(out_id),    32'd0);

    // Literal conversions on requester 2
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'b0100; set_gray(2, lit_g[i]);
      cyc();
      chk("lit_bin", 32'(out_bin), 32'(lit_b[i]));
      chk("lit_id",  32'(out_id),  32'd2);
    end
    // Full sweep, checked by the model each cycle
    for (int g = 0; g < 16; g++) begin
      req_valid = 4'b0100; set_gray(2, 4'(g));
      cyc();
    end
    req_valid = '0;
    cyc();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Sparse: ptr is 3, requesters 1 and 2 valid
    req_valid = 4'b0110;
    #1 chk("sparse_ready1", 32'(req_ready), 32'b0010);
    cyc();
    chk("sparse_id1", 32'(out_id), 32'd1);
    req_valid = 4'b0100;
    #1 chk("sparse_ready2", 32'(req_ready), 32'b0100);
    cyc();
    chk("sparse_id2", 32'(out_id), 32'd2);
    // Again from ptr 3; requester 2 drops before its turn
    req_valid = 4'b0110;
    cyc();
    chk("skip_id1", 32'(out_id), 32'd1);
    req_valid = 4'b1000;
    #1 chk("skip_ready", 32'(req_ready), 32'b1000);
    cyc();
    chk("skip_id3", 32'(out_id), 32'd3);
    req_valid = '0;
    cyc();

    // All valid, continuous round robin from ptr 0
    set_gray(0, 4'b1100); set_gray(1, 4'b0011); set_gray(2, 4'b0101); set_gray(3, 4'b1111);
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_ready", 32'(req_ready), 32'(rr_hot[i]));
      cyc();
      chk("rr_id",    32'(out_id),    32'(i % N));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end
    chk("rr_last_bin", 32'(out_bin), 32'b0010);

    // Backpressure for 3 cycles
    out_ready = 1'b0;
    hold_bin = out_bin;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(req_ready), 32'd0);
      cyc();
      chk("bp_id",  32'(out_id),  32'd1);
      chk("bp_bin", 32'(out_bin), 32'(hold_bin));
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 32'b0100);
    cyc();
    chk("bp_release_id", 32'(out_id), 32'd2);

    // Reset while stalled
    out_ready = 1'b0;
    cyc();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1 chk("rst_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_bin",   32'(out_bin),   32'd0);
    rst = 1'b0; out_ready = 1'b1;
    req_valid = 4'b0110;
    #1 chk("post_rst_ready", 32'(req_ready), 32'b0010);
    cyc();
    chk("post_rst_id", 32'(out_id), 32'd1);
    req_valid = '0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
